// File: rtl/mem_bus_xbar.sv
// Memory-bus crossbar: per-master address decode, per-slave round-robin grant with
// locking, unmapped-address error responses and a per-transaction slave timeout.

module mem_bus_xbar_slv #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [NUM_MASTERS-1:0]                          req_i,
  input  logic [NUM_MASTERS-1:0]                          m_valid_i,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]          m_addr_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]          m_wdata_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0]        m_we_i,
  output logic                                            s_valid_o,
  output logic [ADDR_WIDTH-1:0]                           s_addr_o,
  output logic [DATA_WIDTH-1:0]                           s_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                         s_we_o,
  input  logic                                            s_ready_i,
  output logic [NUM_MASTERS-1:0]                          done_o,
  output logic [NUM_MASTERS-1:0]                          err_o
);
  localparam int MIW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [MIW-1:0]   grant_q, grant_d, rr_q, rr_d, pick;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             found, busy, tmo, fin;

  // First requester at or after rr_q, wrapping around.
  always_comb begin
    int idx;
    idx   = 0;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = (int'(rr_q) + k) % NUM_MASTERS;
      if (!found && req_i[idx[MIW-1:0]]) begin
        found = 1'b1;
        pick  = idx[MIW-1:0];
      end
    end
  end

  assign busy = (state_q == BUSY);
  assign tmo  = (TIMEOUT_CYCLES != 0) && busy && (cnt_q == CW'(TIMEOUT_CYCLES));
  assign fin  = busy && (s_ready_i || tmo);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          grant_d = pick;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (fin) begin
          state_d = IDLE;
          rr_d    = (grant_q == MIW'(NUM_MASTERS - 1)) ? '0 : grant_q + 1'b1;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_valid_o = busy && m_valid_i[grant_q] && !tmo;
    s_addr_o  = busy ? m_addr_i[grant_q]  : '0;
    s_wdata_o = busy ? m_wdata_i[grant_q] : '0;
    s_we_o    = busy ? m_we_i[grant_q]    : '0;
    done_o    = '0;
    err_o     = '0;
    if (fin) begin
      done_o[grant_q] = 1'b1;
      // a ready coinciding with expiry still counts as a normal completion
      err_o[grant_q]  = !s_ready_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

module mem_bus_xbar #(
  parameter int NUM_MASTERS    = 2,
  parameter int NUM_SLAVES     = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {NUM_SLAVES{32'h0}},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_valid_i,
  output logic [NUM_MASTERS-1:0]            m_ready_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_we_i,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata_o,
  output logic [NUM_SLAVES-1:0]             s_valid_o,
  input  logic [NUM_SLAVES-1:0]             s_ready_i,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0]  s_addr_o,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0]  s_wdata_o,
  output logic [NUM_SLAVES*DATA_WIDTH/8-1:0] s_we_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]  s_rdata_i
);
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] BASE = SLAVE_BASE;
  localparam logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] MASK = SLAVE_MASK;

  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0] m_addr;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] m_wdata, m_rdata;
  logic [NUM_MASTERS-1:0][SW-1:0]         m_we;
  logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0]  s_addr;
  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]  s_wdata, s_rdata;
  logic [NUM_SLAVES-1:0][SW-1:0]          s_we;
  logic [NUM_SLAVES-1:0][NUM_MASTERS-1:0] req, done, serr;
  logic [NUM_MASTERS-1:0]                 mapped, err_q, err_d;

  assign m_addr    = m_addr_i;
  assign m_wdata   = m_wdata_i;
  assign m_we      = m_we_i;
  assign s_rdata   = s_rdata_i;
  assign s_addr_o  = s_addr;
  assign s_wdata_o = s_wdata;
  assign s_we_o    = s_we;
  assign m_rdata_o = m_rdata;

  // Lowest-index matching slave wins; req is indexed [slave][master].
  always_comb begin
    req    = '0;
    mapped = '0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      for (int s = 0; s < NUM_SLAVES; s++) begin
        if (!mapped[m] && ((m_addr[m] & MASK[s]) == BASE[s])) begin
          mapped[m] = 1'b1;
          req[s][m] = m_valid_i[m];
        end
      end
    end
  end

  assign err_d = m_valid_i & ~mapped & ~err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_slv
    mem_bus_xbar_slv #(
      .NUM_MASTERS(NUM_MASTERS), .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_slv (
      .clk(clk), .rst(rst), .req_i(req[s]), .m_valid_i(m_valid_i),
      .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_we_i(m_we),
      .s_valid_o(s_valid_o[s]), .s_addr_o(s_addr[s]), .s_wdata_o(s_wdata[s]),
      .s_we_o(s_we[s]), .s_ready_i(s_ready_i[s]), .done_o(done[s]), .err_o(serr[s])
    );
  end

  // A master is served by at most one source per cycle, so plain OR-merge is safe.
  always_comb begin
    m_ready_o = err_q;
    m_err_o   = err_q;
    m_rdata   = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (done[s][m]) begin
          m_ready_o[m] = 1'b1;
          m_err_o[m]   = m_err_o[m] | serr[s][m];
          if (!serr[s][m]) m_rdata[m] = s_rdata[s];
        end
      end
    end
    if (rst) begin
      m_ready_o = '0;
      m_err_o   = '0;
      m_rdata   = '0;
    end
  end
endmodule

// File: tb/tb_mem_bus_xbar.sv
// Bench for mem_bus_xbar: transaction-level model of ownership/age/priority per slave,
// compared against every output each cycle, plus directed literal checks.

module tb_mem_bus_xbar;
  localparam int NM = 2, NS = 4, TMO = 4;
  localparam logic [127:0] BASE = {32'h2000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [127:0] MASK = {32'hF000_0000, 32'hFF00_0000, 32'hF000_0000, 32'hF000_0000};

  logic clk = 1'b0, rst = 1'b1;
  logic [1:0]   m_valid_i = '0, m_ready_o, m_err_o;
  logic [63:0]  m_addr_i = '0, m_wdata_i = '0, m_rdata_o;
  logic [7:0]   m_we_i = '0;
  logic [3:0]   s_valid_o, s_ready_i = '0;
  logic [127:0] s_addr_o, s_wdata_o, s_rdata_i = '0;
  logic [15:0]  s_we_o;

  mem_bus_xbar #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .m_valid_i(m_valid_i), .m_ready_o(m_ready_o), .m_err_o(m_err_o),
    .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i), .m_we_i(m_we_i), .m_rdata_o(m_rdata_o),
    .s_valid_o(s_valid_o), .s_ready_i(s_ready_i), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_we_o(s_we_o), .s_rdata_i(s_rdata_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  bit          rq_v[NM];
  logic [31:0] rq_a[NM], rq_d[NM];
  logic [3:0]  rq_we[NM];
  bit          exp_rdy[NM], upend[NM];
  int          own[NS], age[NS], rr[NS], swait[NS], wmode[NS];
  bit          rd_fix_en = 1'b0;
  logic [31:0] rd_fix = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int dec(input logic [31:0] a);
    for (int s = 0; s < NS; s++)
      if ((a & MASK[s*32 +: 32]) == BASE[s*32 +: 32]) return s;
    return -1;
  endfunction

  function automatic int pick_wait(input int s);
    int k;
    if (wmode[s] != -2) return wmode[s];
    k = $urandom_range(0, 5);
    return (k == 5) ? -1 : k;   // -1: slave never answers
  endfunction

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin own[s] = -1; age[s] = 0; rr[s] = 0; swait[s] = 0; end
    for (int m = 0; m < NM; m++) begin upend[m] = 1'b0; exp_rdy[m] = 1'b0; end
  endtask

  // One bus cycle: drive, respond as slaves, compare, advance the model.
  task automatic step(input bit r);
    bit sr[NS], tm[NS];
    logic [31:0] rd[NS];
    logic [3:0] e_sv; logic [127:0] e_sa, e_sd; logic [15:0] e_swe;
    logic [1:0] e_rdy, e_err; logic [63:0] e_rd;
    int mm;
    @(negedge clk);
    rst = r;
    for (int m = 0; m < NM; m++) begin
      m_valid_i[m] = rq_v[m];
      m_addr_i[m*32 +: 32] = rq_a[m];
      m_wdata_i[m*32 +: 32] = rq_d[m];
      m_we_i[m*4 +: 4] = rq_we[m];
    end
    for (int s = 0; s < NS; s++) begin
      sr[s] = (own[s] >= 0) && (swait[s] >= 0) && (age[s] == swait[s] + 1);
      rd[s] = rd_fix_en ? rd_fix : $urandom;
      s_ready_i[s] = sr[s];
      s_rdata_i[s*32 +: 32] = rd[s];
    end
    #1;
    e_sv = '0; e_sa = '0; e_sd = '0; e_swe = '0; e_rdy = '0; e_err = '0; e_rd = '0;
    for (int s = 0; s < NS; s++) begin
      tm[s] = 1'b0;
      if (own[s] >= 0) begin
        tm[s] = (age[s] == TMO + 1);
        e_sv[s] = !tm[s];
        e_sa[s*32 +: 32] = rq_a[own[s]];
        e_sd[s*32 +: 32] = rq_d[own[s]];
        e_swe[s*4 +: 4] = rq_we[own[s]];
        if (sr[s] || tm[s]) begin
          e_rdy[own[s]] = 1'b1;
          if (sr[s]) e_rd[own[s]*32 +: 32] = rd[s];
          else e_err[own[s]] = 1'b1;
        end
      end
    end
    for (int m = 0; m < NM; m++) if (upend[m]) begin e_rdy[m] = 1'b1; e_err[m] = 1'b1; end
    if (r) begin e_rdy = '0; e_err = '0; e_rd = '0; end
    chk("s_valid", s_valid_o, e_sv);
    chk("s_addr", s_addr_o, e_sa);
    chk("s_wdata", s_wdata_o, e_sd);
    chk("s_we", s_we_o, e_swe);
    chk("m_ready", m_ready_o, e_rdy);
    chk("m_err", m_err_o, e_err);
    chk("m_rdata", m_rdata_o, e_rd);
    for (int m = 0; m < NM; m++) exp_rdy[m] = e_rdy[m];
    if (r) begin
      model_reset();
    end else begin
      for (int s = 0; s < NS; s++) begin
        if (own[s] >= 0) begin
          if (sr[s] || tm[s]) begin rr[s] = (own[s] + 1) % NM; own[s] = -1; end
          else age[s]++;
        end else begin
          for (int k = 0; k < NM; k++) begin
            mm = (rr[s] + k) % NM;
            if (own[s] < 0 && rq_v[mm] && dec(rq_a[mm]) == s) begin
              own[s] = mm; age[s] = 1; swait[s] = pick_wait(s);
            end
          end
        end
      end
      for (int m = 0; m < NM; m++) upend[m] = rq_v[m] && (dec(rq_a[m]) < 0) && !upend[m];
    end
  endtask

  task automatic set_req(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    rq_v[m] = 1'b1; rq_a[m] = a; rq_d[m] = d; rq_we[m] = we;
  endtask

  task automatic gen_rand();
    int k;
    logic [31:0] a;
    for (int m = 0; m < NM; m++) begin
      if (!rq_v[m] || exp_rdy[m]) begin
        if ($urandom_range(0, 9) < 7) begin
          k = $urandom_range(0, 5);
          a = $urandom;
          case (k)
            0: a[31:28] = 4'h0;
            1: a[31:28] = 4'h1;
            2: a[31:24] = 8'h20;
            3: a[31:24] = 8'h21;
            4: a[31:24] = 8'h2A;
            default: a[31:28] = ($urandom_range(0, 1) != 0) ? 4'hF : 4'h4;
          endcase
          set_req(m, a, $urandom, ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom));
        end else rq_v[m] = 1'b0;
      end
    end
  endtask

  initial begin
    int got[$];
    for (int m = 0; m < NM; m++) begin rq_v[m] = 0; rq_a[m] = '0; rq_d[m] = '0; rq_we[m] = '0; end
    for (int s = 0; s < NS; s++) wmode[s] = -2;
    model_reset();
    repeat (3) @(posedge clk);
    step(1); step(1);

    // reset release with idle inputs
    repeat (10) begin
      step(0);
      chk("rst_idle", {s_valid_o, m_ready_o, m_err_o, m_rdata_o, s_addr_o}, '0);
    end

    // zero-wait read through slave1
    wmode[1] = 0; rd_fix_en = 1'b1; rd_fix = 32'hCAFE_F00D;
    set_req(0, 32'h1000_0004, 32'h0, 4'h0);
    step(0);
    step(0);
    chk("zw_svalid1", s_valid_o[1], 1'b1);
    chk("zw_ready0", m_ready_o[0], 1'b1);
    chk("zw_rdata0", m_rdata_o[31:0], 32'hCAFE_F00D);
    chk("zw_err0", m_err_o[0], 1'b0);
    rq_v[0] = 0; rd_fix_en = 1'b0;
    step(0);

    // unmapped write
    set_req(1, 32'hFFFF_0000, 32'h1234_5678, 4'hF);
    step(0);
    step(0);
    chk("um_ready1", m_ready_o[1], 1'b1);
    chk("um_err1", m_err_o[1], 1'b1);
    chk("um_rdata1", m_rdata_o[63:32], 32'h0);
    chk("um_svalid", s_valid_o, 4'h0);
    rq_v[1] = 0;
    step(0);

    // contention on slave0, zero-wait
    wmode[0] = 0;
    set_req(0, 32'h0000_0010, 32'h11, 4'h0);
    set_req(1, 32'h0000_0020, 32'h22, 4'h0);
    repeat (8) begin
      step(0);
      if (m_ready_o[0]) got.push_back(0);
      if (m_ready_o[1]) got.push_back(1);
    end
    chk("ct_count", got.size(), 4);
    if (got.size() == 4) begin
      chk("ct_g0", got[0], 0); chk("ct_g1", got[1], 1);
      chk("ct_g2", got[2], 0); chk("ct_g3", got[3], 1);
    end
    rq_v[0] = 0; rq_v[1] = 0;
    step(0);

    // timeout on a never-ready slave0, then reset mid-transaction of the next grant
    wmode[0] = -1;
    set_req(0, 32'h0000_0100, 32'hA, 4'h0);
    set_req(1, 32'h0000_0200, 32'hB, 4'h0);
    repeat (6) step(0);
    chk("to_ready0", m_ready_o[0], 1'b1);
    chk("to_err0", m_err_o[0], 1'b1);
    chk("to_rdata0", m_rdata_o[31:0], 32'h0);
    chk("to_svalid0", s_valid_o[0], 1'b0);
    rq_v[0] = 0;
    step(0);
    step(0);
    chk("to_next_valid", s_valid_o[0], 1'b1);
    chk("to_next_addr", s_addr_o[31:0], 32'h0000_0200);
    step(1);
    chk("rs_noready", m_ready_o, 2'b00);
    rq_v[1] = 0;
    step(0);
    chk("rs_after", {s_valid_o, m_ready_o, m_err_o, m_rdata_o}, '0);

    // concurrent masters on different slaves
    wmode[0] = 0; wmode[2] = 3;
    set_req(0, 32'h0000_0100, 32'hA5A5_A5A5, 4'h3);
    set_req(1, 32'h2000_0040, 32'h5A5A_5A5A, 4'hC);
    for (int c = 0; c < 6; c++) begin
      step(0);
      if (c == 1) begin
        chk("cc_we0", s_we_o[3:0], 4'h3);
        chk("cc_wd0", s_wdata_o[31:0], 32'hA5A5_A5A5);
        chk("cc_we2", s_we_o[11:8], 4'hC);
        chk("cc_wd2", s_wdata_o[95:64], 32'h5A5A_5A5A);
        chk("cc_rdy0", m_ready_o[0], 1'b1);
      end
      if (c == 4) chk("cc_rdy1", m_ready_o[1], 1'b1);
      for (int m = 0; m < NM; m++) if (exp_rdy[m]) rq_v[m] = 0;
    end

    // randomized traffic
    for (int s = 0; s < NS; s++) wmode[s] = -2;
    repeat (3000) begin
      gen_rand();
      step(0);
    end
    rq_v[0] = 0; rq_v[1] = 0;
    step(1);
    step(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_bus_xbar.md
# mem_bus_xbar

Parametrised memory-bus crossbar connecting NUM_MASTERS requesters (core instruction port, core data port, future DMA) to NUM_SLAVES targets (dual-port RAM, GPIO, UART, timers) over the valid/ready memory bus. It replaces the fixed single-master, three-slave address splitter. New behaviour: a parameter-driven address map, per-slave round-robin arbitration with grant locking, and an error response for unmapped addresses. It also adds a per-transaction timeout.

## Interface
- NUM_MASTERS, 2, requester ports (1..8)
- NUM_SLAVES, 4, target ports (1..16)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; strobe width SW = DATA_WIDTH/8
- SLAVE_BASE, {NUM_SLAVES{32'h0}}, packed base addresses, slave i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- SLAVE_MASK, {NUM_SLAVES{32'h0}}, packed masks; slave i matches when (addr & MASK_i) == BASE_i
- TIMEOUT_CYCLES, 255, max cycles a granted slave may withhold ready; 0 disables
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- m_valid_i  input  NUM_MASTERS  request valid per master
- m_ready_o  output  NUM_MASTERS  transfer complete per master
- m_err_o  output  NUM_MASTERS  qualifies m_ready_o: decode error or timeout
- m_addr_i  input  NUM_MASTERS*ADDR_WIDTH  packed addresses
- m_wdata_i  input  NUM_MASTERS*DATA_WIDTH  packed write data
- m_we_i  input  NUM_MASTERS*SW  byte write strobes; all-zero = read
- m_rdata_o  output  NUM_MASTERS*DATA_WIDTH  read data, valid while m_ready_o
- s_valid_o  output  NUM_SLAVES  request to slave
- s_ready_i  input  NUM_SLAVES  slave completion
- s_addr_o / s_wdata_o / s_we_o  output  NUM_SLAVES*(ADDR_WIDTH/DATA_WIDTH/SW)  forwarded from granted master
- s_rdata_i  input  NUM_SLAVES*DATA_WIDTH  slave read data

## Operation
- Protocol: master raises valid with addr/wdata/we stable and holds them until ready. Ready is a single-cycle completion pulse. One outstanding transaction per master. Dropping valid before ready is illegal.
- Decode: combinational per master. Lowest-index matching slave wins on overlap. No match gives unmapped.
- Per-slave FSM, IDLE/BUSY:
  - IDLE → BUSY when any master requests this slave. The grant goes to the first requester at or after rr_ptr (circular). Grant index is registered.
  - BUSY: s_valid_o = granted master's valid. s_addr/wdata/we are muxed from the granted master. m_ready_o[g] = s_ready_i and m_rdata_o[g] = s_rdata_i, both combinational.
  - BUSY → IDLE on s_ready_i. rr_ptr ← g+1 mod NUM_MASTERS.
  - BUSY → IDLE on timeout: counter reaches TIMEOUT_CYCLES without s_ready_i. That cycle m_ready_o[g]=1, m_err_o[g]=1, m_rdata=0, and s_valid_o is dropped. rr_ptr is updated as above.
- Unmapped request: per-master err_q register is set the cycle after valid is seen unmapped. The following cycle gives m_ready_o=1, m_err_o=1, m_rdata_o=0. err_q then clears. Nothing reaches any slave.
- Non-granted outputs: s_valid_o=0. s_addr/wdata/we are driven 0. m_rdata_o=0 when m_ready_o=0.
- Masters hitting different slaves proceed concurrently with no interaction.

## Timing
- Reset:
  - all s_valid_o, m_ready_o, m_err_o = 0; all data outputs 0
  - FSMs to IDLE; rr_ptr = 0; timeout counters 0; err_q = 0
- Reset mid-transaction aborts it: no ready is returned, and the slave sees valid drop next cycle.
- Latency:
  - request at cycle 0 gives s_valid_o from cycle 1
  - a zero-wait slave (s_ready_i in cycle 1) gives m_ready_o in cycle 1
  - minimum 2 cycles per transfer
- After completion the slave spends at least one cycle in IDLE before the next grant. Back-to-back throughput per slave is one transfer per 2 cycles.
- Simultaneous requests to one IDLE slave are resolved by rr_ptr, with no starvation: each waiting master is served within NUM_MASTERS grants.
- The timeout counter clears on grant and increments each BUSY cycle without s_ready_i. It fires when count == TIMEOUT_CYCLES, i.e. on the (TIMEOUT_CYCLES+1)-th BUSY cycle.
- If s_ready_i and the timeout coincide, the cycle is a normal completion (m_err_o=0).
- Unmapped latency: valid at cycle 0 gives m_ready_o/m_err_o at cycle 1.

## Test plan
- Reset check: release rst with all inputs 0 → every output 0 and no s_valid_o for 10 cycles.
- Zero-wait read: map slave1 base 0x1000_0000 mask 0xF000_0000. Master0 reads 0x1000_0004 while the slave returns 0xCAFE_F00D in the same cycle → s_valid_o[1] at cycle 1, m_ready_o[0] and rdata 0xCAFE_F00D at cycle 1, m_err_o=0.
- Contention: masters 0 and 1 request slave0 on the same cycle continuously with a zero-wait slave → grants alternate 0,1,0,1 starting with 0. Each master completes every 4 cycles.
- Concurrency: master0 accesses slave0 while master1 accesses slave2 with a 3-wait slave → both complete independently; s_we_o/s_wdata_o match their respective masters.
- Unmapped: master1 writes 0xFFFF_0000 with we=4'hF → no s_valid_o anywhere; m_ready_o[1]=1, m_err_o[1]=1, rdata 0 at cycle 1.
- Timeout/reset: set TIMEOUT_CYCLES=4 with a slave that never readies → error completion on BUSY cycle 5, then the next master is granted. A repeat run with rst asserted at BUSY cycle 2 → no ready, all outputs 0 next cycle.
